// File: rtl/box2x_pkg.sv
// Shared types and helpers for the 2x2 box-filter downscaler.
// Pixels carry channels {B,G,R} from MSB to LSB at 4 or 8 bits per channel.
package box2x_pkg;

    localparam int ROUND = 2;

    // Channels are held at the widest size; 4-bit pixels are zero-extended.
    typedef logic [2:0][7:0] chans_t;

    function automatic int chan_w(input bit half_depth);
        return half_depth ? 4 : 8;
    endfunction

    function automatic chans_t unpack_px(input logic [23:0] px, input bit half_depth);
        chans_t c;
        c = '0;
        for (int i = 0; i < 3; i++) begin
            if (half_depth) c[i] = {4'b0, px[i*4 +: 4]};
            else            c[i] = px[i*8 +: 8];
        end
        return c;
    endfunction

    function automatic logic [23:0] pack_px(input chans_t c, input bit half_depth);
        logic [23:0] p;
        p = '0;
        for (int i = 0; i < 3; i++) begin
            if (half_depth) p[i*4 +: 4] = c[i][3:0];
            else            p[i*8 +: 8] = c[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/box2x_if.sv
// Pixel stream bundle: full-resolution input side and half-resolution output side.
interface box2x_if
    import box2x_pkg::*;
#(
    parameter bit HALF_DEPTH = 1'b0
);
    localparam int DWIDTH = 3 * chan_w(HALF_DEPTH) - 1;

    logic              ce_in;
    logic [DWIDTH:0]   inputpixel;
    logic              reset_line;
    logic              reset_frame;
    logic [DWIDTH:0]   outpixel;
    logic              out_valid;
    logic              out_line_start;
    logic              out_frame_start;

    modport master (
        output ce_in, inputpixel, reset_line, reset_frame,
        input  outpixel, out_valid, out_line_start, out_frame_start
    );

    modport slave (
        input  ce_in, inputpixel, reset_line, reset_frame,
        output outpixel, out_valid, out_line_start, out_frame_start
    );

endinterface

// File: rtl/box2x_linebuf.sv
// Simple dual-port line buffer: write-enabled port plus a registered read port.
module box2x_linebuf #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int W     = 27
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/box2x_downscaler.sv
// Half-resolution downscaler: each output pixel is the rounded mean of a 2x2 input block.
// Even lines store horizontal pair sums; odd lines add them back and emit the average.
module box2x_downscaler
    import box2x_pkg::*;
#(
    parameter int LENGTH     = 512,
    parameter bit HALF_DEPTH = 1'b0
) (
    input logic   clk,
    input logic   reset,
    box2x_if.slave bus
);

    localparam int DWIDTH = HALF_DEPTH ? 11 : 23;
    localparam int C      = chan_w(HALF_DEPTH);
    localparam int AW     = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int BW     = 3 * (C + 1);
    localparam logic [AW-1:0] X_LAST = AW'(LENGTH - 1);

    logic [AW-1:0] x;
    logic          parity;
    logic          pair_phase;
    logic          first_line;
    logic          first_px;
    logic          old_reset_line;
    logic          frame_prev;
    logic          restart;
    logic          full;
    logic [23:0]   hold;

    logic [23:0]   px_w;
    logic [23:0]   out_w;
    logic          line_start;
    logic          new_frame;
    logic          parity_n;
    logic [AW-1:0] x_eff;
    logic          phase_eff;
    logic          full_eff;
    logic          counting;
    logic          take;
    logic          pair;
    logic          rd_en;
    logic          wr_en;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;

    chans_t         hc, pc, oc;
    logic [2:0][8:0] hs;
    logic [2:0][9:0] tot;

    assign px_w       = 24'(bus.inputpixel);
    assign line_start = bus.ce_in & old_reset_line & ~bus.reset_line;
    // A post-reset line is forced even so no output is built from a half-seen pair of lines.
    assign new_frame  = frame_prev | restart;
    assign parity_n   = line_start ? (~new_frame & ~parity) : parity;
    assign x_eff      = line_start ? '0 : x;
    assign phase_eff  = ~line_start & pair_phase;
    assign full_eff   = ~line_start & full;
    assign counting   = bus.ce_in & ~bus.reset_line;
    assign take       = counting & ~phase_eff;
    assign pair       = counting & phase_eff & ~full_eff;
    assign rd_en      = take & parity_n;
    assign wr_en      = pair & ~parity_n;

    always_comb begin
        hc    = unpack_px(hold, HALF_DEPTH);
        pc    = unpack_px(px_w, HALF_DEPTH);
        hs    = '0;
        tot   = '0;
        oc    = '0;
        wdata = '0;
        for (int i = 0; i < 3; i++) begin
            hs[i] = {1'b0, hc[i]} + {1'b0, pc[i]};
            wdata[i*(C+1) +: (C+1)] = hs[i][C:0];
            tot[i] = {1'b0, hs[i]} + 10'(rdata[i*(C+1) +: (C+1)]) + 10'(ROUND);
            oc[i]  = tot[i][9:2];
        end
    end

    assign out_w = pack_px(oc, HALF_DEPTH);

    box2x_linebuf #(
        .DEPTH (LENGTH),
        .AW    (AW),
        .W     (BW)
    ) u_linebuf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (x_eff),
        .wdata (wdata),
        .re    (rd_en),
        .raddr (x_eff),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            x                   <= '0;
            parity              <= 1'b0;
            pair_phase          <= 1'b0;
            first_line          <= 1'b1;
            first_px            <= 1'b1;
            old_reset_line      <= 1'b1;
            frame_prev          <= 1'b0;
            restart             <= 1'b1;
            full                <= 1'b0;
            hold                <= '0;
            bus.outpixel        <= '0;
            bus.out_valid       <= 1'b0;
            bus.out_line_start  <= 1'b0;
            bus.out_frame_start <= 1'b0;
        end else begin
            bus.out_valid       <= 1'b0;
            bus.out_line_start  <= 1'b0;
            bus.out_frame_start <= 1'b0;
            if (bus.ce_in) begin
                old_reset_line <= bus.reset_line;
                frame_prev     <= bus.reset_frame;
            end
            if (line_start) begin
                x          <= '0;
                pair_phase <= 1'b0;
                full       <= 1'b0;
                first_px   <= 1'b1;
                restart    <= 1'b0;
                parity     <= parity_n;
                if (new_frame) first_line <= 1'b1;
            end
            if (take) begin
                hold       <= px_w;
                pair_phase <= 1'b1;
            end
            // Pairs past the last buffer slot still complete but are dropped.
            if (counting && phase_eff) begin
                pair_phase <= 1'b0;
                if (!full) begin
                    if (x == X_LAST) full <= 1'b1;
                    else             x    <= x + 1'b1;
                    if (parity) begin
                        bus.outpixel        <= out_w[DWIDTH:0];
                        bus.out_valid       <= 1'b1;
                        bus.out_line_start  <= first_px;
                        bus.out_frame_start <= first_line;
                        first_px            <= 1'b0;
                        first_line          <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_box2x_downscaler.sv
// Directed bench: three downscaler instances (24-bit, 24-bit with a 4-entry buffer, 12-bit)
// share one input stream; each test checks the instance it targets.
module tb_box2x_downscaler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, rl, rf;
    logic [23:0] pix;
    logic        prev_ce = 1'b0;
    int          checks = 0;
    int          errors = 0;
    logic [23:0] lp [16];

    typedef struct packed {
        logic [23:0] px;
        logic        ls;
        logic        fs;
        logic        lat;
    } rec_t;

    rec_t qa[$], qb[$], qc[$];

    always #5 clk = ~clk;

    box2x_if #(.HALF_DEPTH(1'b0)) bus_a ();
    box2x_if #(.HALF_DEPTH(1'b0)) bus_b ();
    box2x_if #(.HALF_DEPTH(1'b1)) bus_c ();

    assign bus_a.ce_in = ce;  assign bus_a.reset_line = rl;
    assign bus_a.reset_frame = rf;  assign bus_a.inputpixel = pix;
    assign bus_b.ce_in = ce;  assign bus_b.reset_line = rl;
    assign bus_b.reset_frame = rf;  assign bus_b.inputpixel = pix;
    assign bus_c.ce_in = ce;  assign bus_c.reset_line = rl;
    assign bus_c.reset_frame = rf;  assign bus_c.inputpixel = pix[11:0];

    box2x_downscaler #(.LENGTH(512), .HALF_DEPTH(1'b0)) dut_a (.clk(clk), .reset(rst), .bus(bus_a));
    box2x_downscaler #(.LENGTH(4),   .HALF_DEPTH(1'b0)) dut_b (.clk(clk), .reset(rst), .bus(bus_b));
    box2x_downscaler #(.LENGTH(512), .HALF_DEPTH(1'b1)) dut_c (.clk(clk), .reset(rst), .bus(bus_c));

    // lat records whether ce was high in the cycle just before the valid pulse.
    always @(negedge clk) begin
        if (bus_a.out_valid)
            qa.push_back({bus_a.outpixel, bus_a.out_line_start, bus_a.out_frame_start, prev_ce});
        if (bus_b.out_valid)
            qb.push_back({bus_b.outpixel, bus_b.out_line_start, bus_b.out_frame_start, prev_ce});
        if (bus_c.out_valid)
            qc.push_back({24'(bus_c.outpixel), bus_c.out_line_start, bus_c.out_frame_start, prev_ce});
        prev_ce = ce;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic rec_t pick(input rec_t q[$], input int i);
        if (i < q.size()) return q[i];
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [23:0] p, input logic l, input logic f, input int gap);
        ce = 1'b1; rl = l; rf = f; pix = p;
        tick();
        ce = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic put_line(input int w, input bit first, input int gap);
        if (first) repeat (3) send(24'h0, 1'b1, 1'b1, gap);
        else       repeat (2) send(24'h0, 1'b1, 1'b0, gap);
        for (int i = 0; i < w; i++) send(lp[i], 1'b0, 1'b0, gap);
    endtask

    task automatic flush();
        rl = 1'b1; rf = 1'b0;
        repeat (4) tick();
    endtask

    task automatic clearq();
        qa.delete(); qb.delete(); qc.delete();
    endtask

    task automatic block(input logic [23:0] a, b, c, d);
        lp[0] = a; lp[1] = b; put_line(2, 1'b1, 0);
        lp[0] = c; lp[1] = d; put_line(2, 1'b0, 0);
        flush();
    endtask

    task automatic const_frame(input string tag, input int gap);
        rec_t r;
        clearq();
        for (int i = 0; i < 16; i++) lp[i] = 24'h102030;
        put_line(8, 1'b1, gap);
        repeat (3) put_line(8, 1'b0, gap);
        flush();
        chk({tag, "_cnt"}, qa.size(), 8);
        for (int i = 0; i < 8; i++) begin
            r = pick(qa, i);
            chk($sformatf("%s_px%0d", tag, i),  r.px, 24'h102030);
            chk($sformatf("%s_ls%0d", tag, i),  r.ls, (i == 0 || i == 4));
            chk($sformatf("%s_fs%0d", tag, i),  r.fs, (i == 0));
            chk($sformatf("%s_lat%0d", tag, i), r.lat, 1);
        end
    endtask

    initial begin
        rec_t r;
        rst = 1'b1; ce = 1'b0; rl = 1'b1; rf = 1'b1; pix = '0;
        repeat (3) tick();
        chk("rst_px",  bus_a.outpixel, 0);
        chk("rst_vld", bus_a.out_valid, 0);
        chk("rst_ls",  bus_a.out_line_start, 0);
        chk("rst_fs",  bus_a.out_frame_start, 0);
        rst = 1'b0;
        tick();

        const_frame("t1", 0);

        // Rounding: 3/4 rounds up, 1/4 rounds down, full scale stays full scale.
        clearq(); block(24'h000000, 24'h000001, 24'h000001, 24'h000001);
        chk("t2a_cnt", qa.size(), 1); r = pick(qa, 0); chk("t2a_px", r.px, 24'h000001);
        clearq(); block(24'h000000, 24'h000000, 24'h000000, 24'h000001);
        chk("t2b_cnt", qa.size(), 1); r = pick(qa, 0); chk("t2b_px", r.px, 24'h000000);
        clearq(); block(24'h0000FF, 24'h0000FF, 24'h0000FF, 24'h0000FF);
        chk("t2c_cnt", qa.size(), 1); r = pick(qa, 0); chk("t2c_px", r.px, 24'h0000FF);
        // B: FF+01+00+02 -> 65, G: 00+FF+00+00 -> 64, R: 80+81+82+83 -> 130.
        clearq(); block(24'hFF0080, 24'h01FF81, 24'h000082, 24'h020083);
        chk("t2d_cnt", qa.size(), 1); r = pick(qa, 0); chk("t2d_px", r.px, 24'h414082);

        clearq(); block(24'h000FFF, 24'h000FFF, 24'h000000, 24'h000000);
        chk("t3_cnt", qc.size(), 1); r = pick(qc, 0); chk("t3_px", r.px, 24'h000888);

        const_frame("t4", 2);

        // 11-pixel lines into a 4-entry buffer; line k pixel i has R = 16k + i.
        clearq();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 11; i++) lp[i] = 24'(16 * k + i);
            put_line(11, (k == 0), 0);
        end
        flush();
        chk("t5_cnt", qb.size(), 8);
        for (int i = 0; i < 8; i++) begin
            r = pick(qb, i);
            chk($sformatf("t5_px%0d", i), r.px, (i < 4) ? 24'(9 + 2 * i) : 24'(41 + 2 * (i - 4)));
        end

        // Reset partway through an odd line, then a fresh even/odd pair.
        for (int i = 0; i < 4; i++) lp[i] = 24'h000004;
        put_line(4, 1'b1, 0);
        put_line(2, 1'b0, 0);
        rst = 1'b1;
        tick();
        chk("t6_rst_px",  bus_a.outpixel, 0);
        chk("t6_rst_vld", bus_a.out_valid, 0);
        chk("t6_rst_ls",  bus_a.out_line_start, 0);
        chk("t6_rst_fs",  bus_a.out_frame_start, 0);
        rst = 1'b0;
        flush();
        clearq();
        lp[0] = 24'd10; lp[1] = 24'd20; lp[2] = 24'd30; lp[3] = 24'd40;
        put_line(4, 1'b0, 0);
        lp[0] = 24'd2;  lp[1] = 24'd4;  lp[2] = 24'd6;  lp[3] = 24'd8;
        put_line(4, 1'b0, 0);
        flush();
        chk("t6_cnt", qa.size(), 2);
        r = pick(qa, 0);
        chk("t6_px0", r.px, 24'd9);
        chk("t6_ls0", r.ls, 1);
        chk("t6_fs0", r.fs, 1);
        r = pick(qa, 1);
        chk("t6_px1", r.px, 24'd21);
        chk("t6_ls1", r.ls, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/box2x_downscaler.md
Name: box2x_downscaler

Overview:
- Inverse companion to the 2x line-buffered upscaler: takes a full-resolution pixel stream and emits a half-resolution stream.
- Each output pixel is the rounded mean of a 2x2 input block.
- Sits on the capture/analog-out side, ahead of frame buffers or encoders that need native-resolution video.
- Uses the same input strobe/line/frame conventions as the scaler input: ce_in, reset_line, reset_frame.

Parameters:
- LENGTH, 512, max output pixels per line. Line buffer depth; address width = $clog2(LENGTH).
- HALF_DEPTH, 0, 1 = 12-bit pixels (4:4:4), 0 = 24-bit pixels (8:8:8). DWIDTH = HALF_DEPTH ? 11 : 23.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- ce_in  in  1  input pixel strobe; all input sampling is qualified by it
- inputpixel  in  DWIDTH+1  input pixel, channels {B,G,R} from MSB to LSB
- reset_line  in  1  high during hblank; a falling edge (sampled on ce_in) starts a line
- reset_frame  in  1  high during vblank; sampled at each line start
- outpixel  out  DWIDTH+1  averaged pixel
- out_valid  out  1  one-clk pulse, outpixel valid
- out_line_start  out  1  high together with out_valid on the first output pixel of each output line
- out_frame_start  out  1  high together with out_valid on the first output pixel of each frame

Behaviour:
- Reset values:
  - All outputs are 0.
  - x counter = 0, parity = 0, pair_phase = 0, first_line = 1, first_px = 1.
  - old_reset_line = 1, so no line start is recognised until a falling edge is seen.
- Line start (ce_in, old_reset_line = 1, reset_line = 0):
  - x = 0, pair_phase = 0, first_px = 1.
  - If reset_frame was high at the previous ce_in: parity = 0 and first_line = 1. Otherwise parity toggles.
  - The pixel on this same ce_in is pixel 0 of the line.
- Channel width: C = HALF_DEPTH ? 4 : 8. Horizontal sums are C+1 bits per channel; vertical sums are C+2 bits.
- Horizontal pairing: pixels are counted only while reset_line = 0.
  - pair_phase 0: latch the pixel into hold. On odd lines, also drive line-buffer read address x.
  - pair_phase 1: hsum = hold + pixel per channel, with no truncation. Then x increments.
- Even line (parity 0): write hsum to the line buffer at address x on the pair_phase 1 ce_in. Buffer word = 3*(C+1) bits. No output is produced.
- Odd line (parity 1):
  - Per channel: total = hsum + buffer[x]; out channel = (total + 2) >> 2.
  - This is round-half-up and never overflows C bits.
- Latency: out_valid pulses exactly 1 clk after the pair_phase 1 ce_in; outpixel holds until the next valid.
- out_line_start is set on the first valid of each odd line.
- out_frame_start is set on the first valid of the first odd line after frame start; first_line is cleared at that point.
- Line buffer read latency is 1 clk. ce_in may be high every clk; the read issued at pair_phase 0 is consumed at pair_phase 1.
- Boundary conditions:
  - x = LENGTH-1 saturates. Further pairs on that line are dropped: no write, no out_valid.
  - A trailing unpaired pixel (odd input width) is discarded at the next line start.
  - An odd line whose x exceeds the preceding even line's width reads stale buffer data. Sources are required to keep line widths constant.
  - reset_line rising mid-pair aborts that pair silently.
  - reset asserted mid-line aborts the line. After reset the first line is treated as even, and no output appears until a full even/odd pair is seen.
  - A single-line frame (vblank after one even line) produces no output.

Decomposition:
- Shared package box2x_pkg:
  - function chan_w(HALF_DEPTH)
  - pack/unpack functions between pixel and per-channel arrays
  - localparam ROUND = 2
- Sub-module box2x_linebuf: simple dual-port RAM with 1-clk registered read and write-enable. It is a plain inferred array with no reset.

Test Plan:
- Test 1, constant frame, 24-bit:
  - Stimulus: 8x4 frame, all pixels 24'h102030, ce_in every clk.
  - Response: 8 out_valid pulses (4 per odd line) with outpixel = 24'h102030, out_line_start on pulses 1 and 5, out_frame_start on pulse 1 only.
- Test 2, rounding:
  - Stimulus: 2x2 block R values 0,1,1,1 (G = B = 0), 24-bit.
  - Response: outpixel R = 1 ((3+2)>>2). Repeat with 0,0,0,1: R = 0. Repeat with 255 x4: R = 255.
- Test 3, HALF_DEPTH = 1:
  - Stimulus: block 12'hFFF, 12'hFFF, 12'h000, 12'h000.
  - Response: outpixel = 12'h888 ((30+2)>>2 = 8 per channel).
- Test 4, gapped strobe:
  - Stimulus: Test 1 with ce_in high 1 clk in 3.
  - Response: identical values and count; each out_valid occurs exactly 1 clk after the completing ce_in.
- Test 5, overflow and odd width:
  - Stimulus: LENGTH = 4, input line of 11 pixels.
  - Response: 4 outputs per odd line, no writes beyond address 3, last pixel dropped, next line aligned at x = 0.
- Test 6, reset mid-odd-line:
  - Stimulus: assert reset for 1 clk mid-odd-line.
  - Response: all outputs 0 immediately. The next line is even (no output), and the following odd line produces correct averages.
